// File: rtl/fetch_pc_stage_if.sv
// Signal bundle between the P5 fetch stage (PC + F/D register) and the rest of the core.
// The stage itself connects through the slave modport; the core/environment uses master.
interface fetch_pc_stage_if;
    logic [31:0] pc_F;
    logic [31:0] instr_F;
    logic        stall_D;
    logic [1:0]  npc_sel_D;
    logic        cmp_true_D;
    logic        likely_D;
    logic [31:0] rs_fwd_D;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        redirect_F;

    modport master (
        output instr_F, stall_D, npc_sel_D, cmp_true_D, likely_D, rs_fwd_D,
        input  pc_F, instr_D, pc_D, pc8_D, redirect_F
    );

    modport slave (
        input  instr_F, stall_D, npc_sel_D, cmp_true_D, likely_D, rs_fwd_D,
        output pc_F, instr_D, pc_D, pc8_D, redirect_F
    );
endinterface

// File: rtl/fetch_pc_stage.sv
// F-stage PC register and F/D pipeline register of the P5 MIPS core: next-PC selection,
// branch delay slot, likely-branch nullify of the delay slot, and hazard stall hold.
module fetch_pc_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_stage_if.slave bus
);
    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_J   = 2'd2;
    localparam logic [1:0] SEL_JR  = 2'd3;

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;

    logic [31:0] w_seq_pc;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_next_pc;
    logic        w_taken;
    logic        w_nullify;

    assign w_seq_pc    = r_pc_f + 32'd4;
    assign w_br_target = r_pc_d + 32'd4 + {{14{r_instr_d[15]}}, r_instr_d[15:0], 2'b00};
    assign w_j_target  = {r_pc_d[31:28], r_instr_d[25:0], 2'b00};

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_taken   = 1'b0;
        w_next_pc = w_seq_pc;
        case (bus.npc_sel_D)
            SEL_SEQ: ;
            SEL_BR: begin
                if (bus.cmp_true_D) begin
                    w_taken   = 1'b1;
                    w_next_pc = w_br_target;
                end
            end
            SEL_J: begin
                w_taken   = 1'b1;
                w_next_pc = w_j_target;
            end
            SEL_JR: begin
                w_taken   = 1'b1;
                w_next_pc = bus.rs_fwd_D;
            end
            default: ;
        endcase
    end

    // A not-taken likely branch squashes its delay slot; fetch simply continues sequentially.
    assign w_nullify = (bus.npc_sel_D == SEL_BR) && bus.likely_D && !bus.cmp_true_D && !bus.stall_D;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_f    <= PC_RESET;
            r_instr_d <= NOP_WORD;
            r_pc_d    <= PC_RESET;
        end else if (!bus.stall_D) begin
            r_pc_f    <= w_next_pc;
            r_pc_d    <= r_pc_f;
            r_instr_d <= w_nullify ? NOP_WORD : bus.instr_F;
        end
    end

    assign bus.pc_F       = r_pc_f;
    assign bus.instr_D    = r_instr_d;
    assign bus.pc_D       = r_pc_d;
    assign bus.pc8_D      = r_pc_d + 32'd8;
    assign bus.redirect_F = w_taken && !bus.stall_D;
endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
- F-stage PC register plus F/D pipeline register of the P5 five-stage MIPS core.
- Resolves next-PC from D-stage decode plus the D-stage branch comparator result (`cmp_true_D`).
- Supplies `pc_F` to instruction memory and latches `instr_F`/`pc_F` into D.
- Implements the MIPS delay slot, "likely"-style delay-slot nullify, and stall hold.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- NOP_WORD, 32'h0000_0000, instruction injected into D on flush.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_F  output  32  current fetch PC, to IM.
- instr_F  input  32  IM read data for pc_F, combinational.
- stall_D  input  1  hazard unit: freeze PC and F/D register.
- npc_sel_D  input  2  0 = sequential, 1 = conditional branch, 2 = j/jal (imm26), 3 = jr (register).
- cmp_true_D  input  1  branch-condition output of the D-stage comparator.
- likely_D  input  1  the branch in D nullifies its delay slot when not taken.
- rs_fwd_D  input  32  forwarded GPR[rs], jr target.
- instr_D  output  32  F/D register: instruction in D.
- pc_D  output  32  F/D register: PC of instr_D.
- pc8_D  output  32  pc_D + 8, link value for jal/bgezal.
- redirect_F  output  1  the next PC is non-sequential this cycle (debug/trace).

Behaviour:
- Reset (asynchronous, `reset` == 0):
  - pc_F = PC_RESET.
  - instr_D = NOP_WORD.
  - pc_D = PC_RESET.
  - All hold while reset is low.
  - Release is synchronous to the next clk edge; first fetch is at PC_RESET.
- Decode inside the block, all from instr_D:
  - imm16 = instr_D[15:0].
  - imm26 = instr_D[25:0].
  - br_target = pc_D + 4 + (sign_ext(imm16) << 2).
  - j_target = {pc_D[31:28], imm26, 2'b00}.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is not flagged.
- taken:
  - npc_sel_D==1 and cmp_true_D → taken.
  - npc_sel_D==2 or 3 → taken (unconditional).
  - npc_sel_D==0, or ==1 with cmp_true_D==0 → not taken.
- next_pc:
  - taken → br_target / j_target / rs_fwd_D, selected by npc_sel_D.
  - not taken → pc_F + 4.
- redirect_F = taken and !stall_D (combinational).
- Delay slot: the instruction at pc_D+4 is already in F when the branch is in D. It is always latched into D unless nullified.
- Nullify: npc_sel_D==1 and likely_D and !cmp_true_D and !stall_D. At the next edge:
  - instr_D <= NOP_WORD.
  - pc_D <= pc_F.
  - pc_F <= pc_F + 4.
- Stall priority: stall_D==1 wins over branch, jump and nullify.
  - pc_F, instr_D and pc_D all hold.
  - redirect_F = 0.
  - The branch re-evaluates with fresh cmp_true_D and rs_fwd_D after the stall clears.
- Normal edge (no stall, no nullify):
  - pc_F <= next_pc.
  - instr_D <= instr_F.
  - pc_D <= pc_F.
- pc8_D = pc_D + 8 (combinational, modulo 2^32).
- Alignment and range: jr to an unaligned target or outside IM range is passed through unchanged. No exceptions in this stage.
- Latency: a branch resolved in D redirects fetch at the following edge. Zero bubbles beyond the delay slot.
- npc_sel_D is ignored when instr_D == NOP_WORD (decode supplies 0; no extra check required).

Test Plan:
- Reset low mid-run with pc_F = 0x3010 → pc_F = 0x3000 and instr_D = 0 immediately, without a clock edge. Release → fetch sequence 0x3000, 0x3004, 0x3008.
- beq in D at pc_D = 0x3004, imm16 = 0x0003, cmp_true_D = 1 → delay slot at 0x3008 enters D; next pc_F = 0x3014; redirect_F = 1 for one cycle.
- Backward branch, imm16 = 0xFFFF, at pc_D = 0x3008, taken → pc_F = 0x3008. Same case with cmp_true_D = 0 → pc_F = 0x3010.
- Likely branch, likely_D = 1, cmp_true_D = 0, pc_D = 0x3020 → instr_D = 0 next cycle, pc_D = 0x3024, pc_F = 0x3028.
- stall_D = 1 for 2 cycles while jr with rs_fwd_D = 0x3400 sits in D → pc_F, instr_D and pc_D constant, redirect_F = 0. After release → pc_F = 0x3400 and pc8_D is correct for the jal/bgezal link.
- j at pc_D = 0x3FFC, imm26 = 0x0000C00 → pc_F = 0x0000_3000. pc8_D = 0x4004.
